scram_page_ctrl: RTL and testbench

Page-level sequencer that sits directly upstream of the 16-bit NAND data scrambler. It pulls words from the write buffer, reseeds the scrambler LFSR at every page boundary, and issues one scrambler advance per accepted word. It captures the scrambled word returned one cycle later and delivers it to the flash bus with a valid/ready handshake, last-word marking and backpressure. Each page is exactly PAGE_WORDS words long.

---
 rtl/scram_page_ctrl.sv | 140 ++++++++++++++
 tb/tb_scram_page_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scram_page_ctrl.sv
// scram_page_ctrl: page-level sequencer in front of the 16-bit NAND data
// scrambler. It reseeds the scrambler at each page start, pulls PAGE_WORDS
// words from the write buffer, and issues one scrambler advance per accepted
// word. It then holds each scrambled word in a one-entry output slot and
// delivers it to the flash bus with valid/ready, last-word marking and
// backpressure.
module scram_page_ctrl #(
  parameter int PAGE_WORDS = 4096,
  parameter int CNT_W      = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        page_start,
  input  logic        abort,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] scr_data_in,
  output logic        scr_en,
  output logic        scr_rst,
  input  logic [15:0] scr_data_out,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        page_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // in_cnt needs one extra bit: it has to hold PAGE_WORDS itself, and that
  // value may equal 2^CNT_W.
  localparam logic [CNT_W:0]   IN_FULL  = (CNT_W+1)'(PAGE_WORDS);
  localparam logic [CNT_W:0]   IN_LAST  = (CNT_W+1)'(PAGE_WORDS - 1);
  localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(PAGE_WORDS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W:0]   in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic             out_valid_q;
  logic             abort_q;
  logic             out_accept;
  logic             slot_free;

  // The scrambler data path is pure wiring: the word goes in and comes back
  // unregistered on this side.
  assign scr_data_in = in_data;
  assign out_data    = scr_data_out;

  // Handshake decode. The output slot can take a new word when it is empty
  // or is being emptied downstream in the same cycle.
  assign out_valid  = out_valid_q;
  assign out_accept = out_valid_q && out_ready;
  assign slot_free  = !out_valid_q || out_ready;
  assign in_ready   = (state == RUN) && (in_cnt < IN_FULL) && slot_free;
  assign scr_en     = in_valid && in_ready;
  assign out_last   = out_valid_q && (out_cnt == OUT_LAST);

  // Status and scrambler reseed. Reseed happens on SEED and also in the
  // cycle after an abort, so that an abandoned page never leaks LFSR state.
  assign scr_rst   = (state == SEED) || abort_q;
  assign busy      = (state != IDLE);
  assign page_done = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so that every
      // register samples values from before the edge, whatever the block order.
      state <= state_nxt;
    end
  end

  // Next-state logic. abort overrides every transition, including page_start.
  always_comb begin
    // NOTE: default first, so that no path through the case leaves state_nxt
    // unassigned. A missing default would infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE:    if (page_start) state_nxt = SEED;
      SEED:    state_nxt = RUN;
      RUN:     if (scr_en && (in_cnt == IN_LAST)) state_nxt = DRAIN;
      DRAIN:   if (out_accept && out_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Word counters. They are held at zero while idle or aborting. They
  // saturate and never wrap: in_cnt stops at PAGE_WORDS because in_ready
  // drops there, and out_cnt stops at PAGE_WORDS-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (abort || (state == IDLE)) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (scr_en) in_cnt <= in_cnt + 1'b1;
      if (out_accept && (out_cnt != OUT_LAST)) out_cnt <= out_cnt + 1'b1;
    end
  end

  // One-entry output slot. The scrambler answers one cycle after scr_en, so
  // the slot becomes valid then. A drain and a new advance in the same cycle
  // keep the slot full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
    end else if (abort) begin
      out_valid_q <= 1'b0;
    end else if (scr_en) begin
      out_valid_q <= 1'b1;
    end else if (out_accept) begin
      out_valid_q <= 1'b0;
    end
  end

  // Delayed abort, which produces the reseed pulse in the cycle after an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort_q <= 1'b0;
    end else begin
      abort_q <= abort;
    end
  end

endmodule

// File: tb/tb_scram_page_ctrl.sv
// tb_scram_page_ctrl: bench for scram_page_ctrl with PAGE_WORDS=8. It contains
// a stand-in scrambler (16-bit LFSR, all-ones seed) and a page-level reference
// model. The model predicts every scrambled word as data XOR keystream[index
// within page]. It also predicts busy, page_done and reseed pulses from the
// page rules.
module tb_scram_page_ctrl;

  localparam int PAGE  = 8;
  localparam int CNT_W = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        page_start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] scr_data_in;
  logic        scr_en;
  logic        scr_rst;
  logic [15:0] scr_data_out = '0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        busy;
  logic        page_done;

  int total = 0;
  int bad   = 0;
  int nword = 0;

  scram_page_ctrl #(.PAGE_WORDS(PAGE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .page_start(page_start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .scr_data_in(scr_data_in), .scr_en(scr_en), .scr_rst(scr_rst),
    .scr_data_out(scr_data_out), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy),
    .page_done(page_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // k-th keystream word after a reseed.
  function automatic logic [15:0] key(input int idx);
    logic [15:0] l;
    l = 16'hFFFF;
    for (int i = 0; i < idx; i++) l = lfsr_step(l);
    return l;
  endfunction

  // Stand-in scrambler: reseed on scram_rst, XOR and advance on scram_en.
  logic [15:0] lfsr_q = 16'hFFFF;
  always @(posedge clk) begin
    if (scr_rst) begin
      lfsr_q <= 16'hFFFF;
    end else if (scr_en) begin
      scr_data_out <= scr_data_in ^ lfsr_q;
      lfsr_q       <= lfsr_step(lfsr_q);
    end
  end

  function automatic logic [6:0] outs();
    return {in_ready, scr_en, scr_rst, out_valid, out_last, busy, page_done};
  endfunction

  // Reference model, evaluated once per cycle on the falling edge.
  typedef struct {
    logic [15:0] data;
    int          idx;
  } exp_t;

  initial begin : monitor
    exp_t q[$];
    exp_t e;
    bit m_busy, exp_rst, exp_done, exp_ov, nxt_rst, nxt_done, nxt_ov;
    int m_in, m_out;
    m_busy = 0; exp_rst = 0; exp_done = 0; exp_ov = 0; m_in = 0; m_out = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        m_busy = 0; exp_rst = 0; exp_done = 0; exp_ov = 0; m_in = 0; m_out = 0;
      end else begin
        check("m_busy", busy, m_busy);
        check("m_page_done", page_done, exp_done);
        check("m_scr_rst", scr_rst, exp_rst);
        if (exp_ov) check("m_latency", out_valid, 1);
        if (out_valid && !out_ready) check("m_backpressure", in_ready, 0);
        if (m_in == PAGE) check("m_in_cap", in_ready, 0);
        if (page_done) check("m_words_out", m_out, PAGE);
        nxt_done = 0;
        nxt_ov   = 0;
        nxt_rst  = 0;
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            check("m_spurious_out", 1, 0);
          end else begin
            e = q.pop_front();
            check("m_out_data", out_data, e.data);
            check("m_out_last", out_last, e.idx == PAGE - 1);
            m_out++;
            if (e.idx == PAGE - 1) nxt_done = 1;
          end
        end
        if (in_valid && in_ready) begin
          q.push_back('{data: in_data ^ key(m_in), idx: m_in});
          m_in++;
          nxt_ov = 1;
        end
        if (abort) begin
          q.delete();
          m_busy = 0; m_in = 0; m_out = 0;
          nxt_rst = 1; nxt_done = 0; nxt_ov = 0;
        end else if (page_start && !m_busy) begin
          m_busy = 1; m_in = 0; m_out = 0;
          nxt_rst = 1;
        end else if (exp_done) begin
          m_busy = 0;
        end
        exp_done = nxt_done;
        exp_rst  = nxt_rst;
        exp_ov   = nxt_ov;
      end
    end
  end

  // One cycle: drive just after the rising edge, return at the falling edge.
  task automatic drive(input logic ps, input logic iv, input logic ordy,
                       input logic ab, input logic [15:0] d);
    @(posedge clk);
    #1;
    page_start = ps; in_valid = iv; out_ready = ordy; abort = ab; in_data = d;
    @(negedge clk);
    if (in_valid && in_ready) nword++;
  endtask

  // mode 0: streaming, 1: out_ready 1,0,0,1 pattern, 2: random,
  // 3: streaming with a stray page_start during RUN.
  task automatic run_page(input int mode);
    logic       iv, ordy, ps;
    logic [15:0] d;
    logic [3:0] pat;
    bit done;
    pat  = 4'b1001;
    nword = 0;
    done = 0;
    drive(1, 0, 1, 0, 0);
    for (int k = 0; k < 400 && !done; k++) begin
      ps = (mode == 3) && (k == 4);
      iv = 1; ordy = 1; d = 16'(nword);
      if (mode == 1) ordy = pat[k % 4];
      if (mode == 2) begin
        iv   = $urandom_range(0, 3) != 0;
        ordy = $urandom_range(0, 2) != 0;
        d    = 16'($urandom);
      end
      drive(ps, iv, ordy, 0, d);
      if (k == 0) check("seed_pulse", scr_rst, 1);
      if (ps) check("ignored_start_busy", busy, 1);
      if (page_done) done = 1;
    end
    check("page_finished", done, 1);
  endtask

  typedef struct {
    logic       ps;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // Golden streaming page. Outputs are {in_ready, scr_en, scr_rst,
    // out_valid, out_last, busy, page_done}.
    tbl[0]  = '{1'b1, 7'b0000000};
    tbl[1]  = '{1'b0, 7'b0010010};
    tbl[2]  = '{1'b0, 7'b1100010};
    for (int i = 3; i <= 9; i++) tbl[i] = '{1'b0, 7'b1101010};
    tbl[10] = '{1'b0, 7'b0001110};
    tbl[11] = '{1'b0, 7'b0000011};
    tbl[12] = '{1'b0, 7'b0000000};

    @(negedge clk);
    check("reset_state", outs(), 7'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) drive(0, 0, 0, 0, 0);
    check("idle_after_reset", outs(), 7'b0);

    nword = 0;
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].ps, 1, 1, 0, 16'(nword));
      check($sformatf("stream_c%0d", i), outs(), tbl[i].exp);
    end
    check("stream_words_in", nword, PAGE);

    // Backpressure, then a back-to-back page straight after page_done.
    run_page(1);
    run_page(0);

    // Abort after three accepted words.
    nword = 0;
    drive(1, 0, 1, 0, 0);
    for (int k = 0; k < 20 && nword < 3; k++) drive(0, 1, 1, 0, 16'(nword));
    check("abort_setup", nword, 3);
    drive(0, 0, 1, 1, 0);
    drive(0, 0, 1, 0, 0);
    check("abort_ov", out_valid, 0);
    check("abort_rst", scr_rst, 1);
    check("abort_busy", busy, 0);
    repeat (3) begin
      drive(0, 0, 1, 0, 0);
      check("abort_no_done", page_done, 0);
    end
    run_page(0);

    // Stray page_start in RUN, then page_start together with abort.
    run_page(3);
    drive(1, 0, 1, 0, 0);
    repeat (3) drive(0, 1, 1, 0, 16'h1234);
    drive(1, 0, 1, 1, 0);
    drive(0, 0, 1, 0, 0);
    check("start_abort_busy", busy, 0);
    check("start_abort_rst", scr_rst, 1);
    drive(0, 0, 1, 0, 0);
    check("start_abort_no_seed", {busy, scr_rst}, 2'b00);

    // Asynchronous reset in the middle of RUN.
    drive(1, 0, 1, 0, 0);
    repeat (4) drive(0, 1, 1, 0, 16'hBEEF);
    #1 rst_n = 1'b0;
    #1 check("rst_mid_run", outs(), 7'b0);
    page_start = 0; in_valid = 0; abort = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) drive(0, 0, 1, 0, 0);
    check("rst_recover", {busy, page_done}, 2'b00);
    run_page(0);

    // Randomized pages checked by the model.
    repeat (4) run_page(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
